uart_rx_port: RTL and testbench

UART_RX_PORT -- requirements
Module: uart_rx_port

---
 rtl/uart_pkg.sv | 16 +
 rtl/rx_sync.sv | 23 ++
 rtl/uart_rx_port.sv | 146 ++++++++++++++
 tb/tb_uart_rx_port.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Constants and state encoding shared by the UART receiver and transmitter.
package uart_pkg;

  localparam int CPB_W = 12;
  localparam logic [CPB_W-1:0] CPB_MIN  = 12'd4;
  localparam logic [CPB_W-1:0] CPB_9600 = 12'hD05;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_START     = 3'd1,
    ST_DATA      = 3'd2,
    ST_STOP      = 3'd3,
    ST_WAIT_HIGH = 3'd4
  } rx_state_e;

endpackage

// File: rtl/rx_sync.sv
// Multi-flop synchroniser for the asynchronous serial line; resets to the idle (high) level.
module rx_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic q_o
);

  logic [SYNC_STAGES-1:0] sync_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '1;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], d_i};
    end
  end

  assign q_o = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/uart_rx_port.sv
// UART 8N1 receiver with per-frame latched bit time.
// Define UART_RX_FRAME_ERR_EN to add stop-bit checking and the o_RX_Err strobe.
module uart_rx_port
  import uart_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [CPB_W-1:0] i_Clk_per_bit,
  input  logic             i_RX_Serial,
  output logic             o_RX_DV,
  output logic [7:0]       o_RX_Byte,
  output logic             o_RX_Active
`ifdef UART_RX_FRAME_ERR_EN
  ,
  output logic             o_RX_Err
`endif
);

  function automatic logic [CPB_W-1:0] clamp_cpb(input logic [CPB_W-1:0] cpb);
    return (cpb < CPB_MIN) ? CPB_MIN : cpb;
  endfunction

  logic             rx_s;
  rx_state_e        state_q, state_d;
  logic [CPB_W-1:0] cnt_q, cnt_d;
  logic [CPB_W-1:0] cpb_q, cpb_d;
  logic [2:0]       idx_q, idx_d;
  logic [7:0]       shift_q, shift_d;
  logic [7:0]       byte_q, byte_d;
  logic             dv_q, dv_d;
`ifdef UART_RX_FRAME_ERR_EN
  logic             err_q, err_d;
`endif

  rx_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk (clk),
    .rst (rst),
    .d_i (i_RX_Serial),
    .q_o (rx_s)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      cpb_q   <= CPB_9600;
      idx_q   <= '0;
      shift_q <= '0;
      byte_q  <= '0;
      dv_q    <= 1'b0;
`ifdef UART_RX_FRAME_ERR_EN
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cpb_q   <= cpb_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      byte_q  <= byte_d;
      dv_q    <= dv_d;
`ifdef UART_RX_FRAME_ERR_EN
      err_q   <= err_d;
`endif
    end
  end

  // Counter is cleared at every compare point, so it never exceeds cpb_q-1.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cpb_d   = cpb_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    byte_d  = byte_q;
    dv_d    = 1'b0;
`ifdef UART_RX_FRAME_ERR_EN
    err_d   = 1'b0;
`endif
    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        idx_d = '0;
        if (!rx_s) begin
          state_d = ST_START;
          cpb_d   = clamp_cpb(i_Clk_per_bit);
        end
      end
      ST_START: begin
        if (cnt_q == (cpb_q >> 1)) begin
          cnt_d   = '0;
          state_d = rx_s ? ST_IDLE : ST_DATA;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_DATA: begin
        if (cnt_q == cpb_q - 1'b1) begin
          cnt_d          = '0;
          shift_d[idx_q] = rx_s;
          idx_d          = idx_q + 3'd1;
          if (idx_q == 3'd7) state_d = ST_STOP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_STOP: begin
        if (cnt_q == cpb_q - 1'b1) begin
          cnt_d = '0;
`ifdef UART_RX_FRAME_ERR_EN
          if (rx_s) begin
            byte_d  = shift_q;
            dv_d    = 1'b1;
            state_d = ST_IDLE;
          end else begin
            err_d   = 1'b1;
            state_d = ST_WAIT_HIGH;
          end
`else
          byte_d  = shift_q;
          dv_d    = 1'b1;
          state_d = rx_s ? ST_IDLE : ST_WAIT_HIGH;
`endif
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_WAIT_HIGH: begin
        if (rx_s) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    o_RX_Active = (state_q != ST_IDLE);
    o_RX_DV     = dv_q;
    o_RX_Byte   = byte_q;
`ifdef UART_RX_FRAME_ERR_EN
    o_RX_Err    = err_q;
`endif
  end

endmodule

// File: tb/tb_uart_rx_port.sv
// Directed bench for uart_rx_port; honours UART_RX_FRAME_ERR_EN like the design.
module tb_uart_rx_port;
  import uart_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [11:0] cpb = CPB_9600;
  logic        rx_line = 1'b1;
  logic        dv;
  logic [7:0]  rx_byte;
  logic        active;
`ifdef UART_RX_FRAME_ERR_EN
  logic        rx_err;
`endif

  int checks = 0;
  int errors = 0;
  int dv_cnt = 0;
  int err_cnt = 0;
  logic [7:0] rx_q[$];

  always #5 clk = ~clk;

  uart_rx_port #(.SYNC_STAGES(2)) dut (
    .clk           (clk),
    .rst           (rst),
    .i_Clk_per_bit (cpb),
    .i_RX_Serial   (rx_line),
    .o_RX_DV       (dv),
    .o_RX_Byte     (rx_byte),
    .o_RX_Active   (active)
`ifdef UART_RX_FRAME_ERR_EN
    ,
    .o_RX_Err      (rx_err)
`endif
  );

  always @(negedge clk) begin
    if (dv) begin
      dv_cnt++;
      rx_q.push_back(rx_byte);
    end
`ifdef UART_RX_FRAME_ERR_EN
    if (rx_err) err_cnt++;
    if (dv || rx_err) begin
      checks++;
      if (dv && rx_err) begin
        errors++;
        $display("FAIL dv_err_exclusive: dv=%0b err=%0b, required not both", dv, rx_err);
      end
    end
`endif
  end

  // Called at a negedge; leaves the line at the stop-bit level.
  task automatic send_frame(input logic [7:0] b, input logic stop_bit, input int bit_cycles);
    rx_line = 1'b0;
    repeat (bit_cycles) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx_line = b[i];
      repeat (bit_cycles) @(negedge clk);
    end
    rx_line = stop_bit;
    repeat (bit_cycles) @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    rx_line = 1'b1;
    repeat (4) @(negedge clk);
    checks++; if (dv !== 1'b0) begin errors++; $display("FAIL reset_dv: got %0b want 0", dv); end
    checks++; if (rx_byte !== 8'h00) begin errors++; $display("FAIL reset_byte: got %h want 00", rx_byte); end
    checks++; if (active !== 1'b0) begin errors++; $display("FAIL reset_active: got %0b want 0", active); end
`ifdef UART_RX_FRAME_ERR_EN
    checks++; if (rx_err !== 1'b0) begin errors++; $display("FAIL reset_err: got %0b want 0", rx_err); end
`endif
    rst = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_single_byte();
    int c;
    int lat;
    int exp_lat;
    int base;
    c = 3333;
    // floor(c/2)+1+9c from the first synchronised-low cycle, plus 3 cycles through the 2-flop synchroniser and output register
    exp_lat = (c / 2) + 1 + 9 * c + 3;
    lat = 0;
    base = dv_cnt;
    cpb = CPB_9600;
    @(negedge clk);
    fork
      send_frame(8'hAF, 1'b1, c);
      begin
        for (int i = 1; i <= 40000; i++) begin
          @(negedge clk);
          if (dv) begin
            lat = i;
            break;
          end
        end
      end
    join
    repeat (10) @(negedge clk);
    checks++; if (lat != exp_lat) begin errors++; $display("FAIL af_latency: got %0d want %0d", lat, exp_lat); end
    checks++; if (dv_cnt != base + 1) begin errors++; $display("FAIL af_dv_count: got %0d want %0d", dv_cnt - base, 1); end
    checks++; if (rx_byte !== 8'hAF) begin errors++; $display("FAIL af_byte: got %h want af", rx_byte); end
  endtask

  task automatic test_glitch();
    int base;
    int ebase;
    base = dv_cnt;
    ebase = err_cnt;
    cpb = CPB_9600;
    rx_line = 1'b0;
    repeat (50) @(negedge clk);
    checks++; if (active !== 1'b1) begin errors++; $display("FAIL glitch_active_mid: got %0b want 1", active); end
    repeat (50) @(negedge clk);
    rx_line = 1'b1;
    repeat (2000) @(negedge clk);
    checks++; if (active !== 1'b0) begin errors++; $display("FAIL glitch_idle: got %0b want 0", active); end
    checks++; if (dv_cnt != base) begin errors++; $display("FAIL glitch_dv: got %0d strobes want 0", dv_cnt - base); end
    checks++; if (rx_byte !== 8'hAF) begin errors++; $display("FAIL glitch_byte: got %h want af", rx_byte); end
    checks++; if (err_cnt != ebase) begin errors++; $display("FAIL glitch_err: got %0d strobes want 0", err_cnt - ebase); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp_b [3];
    logic [7:0] got;
    int base;
    int qbase;
    exp_b[0] = 8'hCD;
    exp_b[1] = 8'h54;
    exp_b[2] = 8'hEB;
    base = dv_cnt;
    qbase = rx_q.size();
    cpb = 12'd16;
    for (int k = 0; k < 3; k++) send_frame(exp_b[k], 1'b1, 16);
    repeat (20) @(negedge clk);
    checks++; if (dv_cnt != base + 3) begin errors++; $display("FAIL b2b_count: got %0d want 3", dv_cnt - base); end
    for (int k = 0; k < 3; k++) begin
      got = (rx_q.size() > qbase + k) ? rx_q[qbase + k] : 8'hxx;
      checks++;
      if (got !== exp_b[k]) begin errors++; $display("FAIL b2b_byte%0d: got %h want %h", k, got, exp_b[k]); end
    end
  endtask

  task automatic test_stop_error();
    int base;
    int ebase;
    int mid;
    base = dv_cnt;
    ebase = err_cnt;
    cpb = 12'd16;
    send_frame(8'h55, 1'b0, 16);
    repeat (12 * 16) @(negedge clk);
    checks++; if (active !== 1'b1) begin errors++; $display("FAIL stop0_wait_high: got %0b want 1", active); end
`ifdef UART_RX_FRAME_ERR_EN
    checks++; if (err_cnt != ebase + 1) begin errors++; $display("FAIL stop0_err: got %0d strobes want 1", err_cnt - ebase); end
    checks++; if (dv_cnt != base) begin errors++; $display("FAIL stop0_dv: got %0d strobes want 0", dv_cnt - base); end
    checks++; if (rx_byte !== 8'hEB) begin errors++; $display("FAIL stop0_byte: got %h want eb", rx_byte); end
`else
    checks++; if (dv_cnt != base + 1) begin errors++; $display("FAIL stop0_dv: got %0d strobes want 1", dv_cnt - base); end
    checks++; if (rx_byte !== 8'h55) begin errors++; $display("FAIL stop0_byte: got %h want 55", rx_byte); end
`endif
    mid = dv_cnt;
    rx_line = 1'b1;
    repeat (30) @(negedge clk);
    checks++; if (active !== 1'b0) begin errors++; $display("FAIL stop0_idle: got %0b want 0", active); end
    checks++; if (dv_cnt != mid) begin errors++; $display("FAIL stop0_no_restart: got %0d extra strobes want 0", dv_cnt - mid); end
  endtask

  task automatic test_reset_mid_frame();
    int base;
    cpb = 12'd16;
    base = dv_cnt;
    // 0xF0 keeps the line high from bit 4 onward, so no spurious start follows the abort
    fork
      send_frame(8'hF0, 1'b1, 16);
      begin
        repeat (16 + 4 * 16 + 8) @(negedge clk);
        checks++; if (active !== 1'b1) begin errors++; $display("FAIL rstmid_active_before: got %0b want 1", active); end
        rst = 1'b1;
        @(negedge clk);
        checks++; if (dv !== 1'b0) begin errors++; $display("FAIL rstmid_dv: got %0b want 0", dv); end
        checks++; if (rx_byte !== 8'h00) begin errors++; $display("FAIL rstmid_byte: got %h want 00", rx_byte); end
        checks++; if (active !== 1'b0) begin errors++; $display("FAIL rstmid_active: got %0b want 0", active); end
`ifdef UART_RX_FRAME_ERR_EN
        checks++; if (rx_err !== 1'b0) begin errors++; $display("FAIL rstmid_err: got %0b want 0", rx_err); end
`endif
        rst = 1'b0;
      end
    join
    repeat (10) @(negedge clk);
    checks++; if (dv_cnt != base) begin errors++; $display("FAIL rstmid_no_strobe: got %0d strobes want 0", dv_cnt - base); end
    send_frame(8'h3C, 1'b1, 16);
    repeat (10) @(negedge clk);
    checks++; if (dv_cnt != base + 1) begin errors++; $display("FAIL rstmid_3c_count: got %0d want 1", dv_cnt - base); end
    checks++; if (rx_byte !== 8'h3C) begin errors++; $display("FAIL rstmid_3c_byte: got %h want 3c", rx_byte); end
  endtask

  task automatic test_min_cpb();
    int base;
    base = dv_cnt;
    cpb = 12'd4;
    send_frame(8'h81, 1'b1, 4);
    repeat (10) @(negedge clk);
    checks++; if (dv_cnt != base + 1) begin errors++; $display("FAIL cpb4_count: got %0d want 1", dv_cnt - base); end
    checks++; if (rx_byte !== 8'h81) begin errors++; $display("FAIL cpb4_byte: got %h want 81", rx_byte); end
    base = dv_cnt;
    cpb = 12'd2;
    send_frame(8'h81, 1'b1, 4);
    repeat (10) @(negedge clk);
    checks++; if (dv_cnt != base + 1) begin errors++; $display("FAIL cpb2_count: got %0d want 1", dv_cnt - base); end
    checks++; if (rx_byte !== 8'h81) begin errors++; $display("FAIL cpb2_byte: got %h want 81", rx_byte); end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_single_byte();
    test_glitch();
    test_back_to_back();
    test_stop_error();
    test_reset_mid_frame();
    test_min_cpb();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
